decoder_scan_nto2n: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable, polarity option and a built-in scan mode. In scan mode the active output walks through all 2^N lines, one step every HOLD cycles. It is the clocked successor to the combinational 2-to-4 decoder. It drives row/digit/channel-select lines in display-multiplexing and bus-select datapaths, replacing testbench-style free-running stimulus with a synthesizable sequencer.

---
 rtl/decoder_scan_nto2n_pkg.sv | 18 +
 rtl/decoder_scan_nto2n_onehot_enc.sv | 20 ++
 rtl/decoder_scan_nto2n.sv | 84 ++++++++
 tb/tb_decoder_scan_nto2n.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_nto2n_pkg.sv
// Shared definitions for the scanning N-to-2^N decoder: mode encoding and width helpers.
package decoder_scan_nto2n_pkg;

    typedef enum logic {
        MODE_DECODE = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

    function automatic int unsigned out_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // The hold counter keeps at least one bit so HOLD=1 still has a legal register.
    function automatic int unsigned hold_width(input int unsigned hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/decoder_scan_nto2n_onehot_enc.sv
// Combinational N-to-2^N one-hot encoder with optional active-low output.
module onehot_enc
    import decoder_scan_nto2n_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic [N-1:0]              sel,
    output logic [out_width(N)-1:0]   y
);

    always_comb begin
        y      = '0;
        y[sel] = 1'b1;
        if (ACTIVE_LOW) begin
            y = ~y;
        end
    end

endmodule

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N decoder with enable, polarity option and a HOLD-paced scan sequencer.
module decoder_scan_nto2n
    import decoder_scan_nto2n_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned HOLD       = 20,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic                      load,
    input  logic [N-1:0]              sel_in,
    output logic [out_width(N)-1:0]   y,
    output logic [N-1:0]              idx,
    output logic                      wrap
);

    localparam int unsigned W  = out_width(N);
    localparam int unsigned HW = hold_width(HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [W-1:0]  Y_IDLE    = {W{ACTIVE_LOW}};

    mode_t          mode_sel;
    logic [HW-1:0]  hold_cnt;
    logic [HW-1:0]  hold_next;
    logic [N-1:0]   idx_next;
    logic [W-1:0]   y_enc;
    logic [W-1:0]   y_next;
    logic           wrap_next;

    always_comb begin
        mode_sel = mode_t'(mode);
    end

    // Encoder sits on idx_next so a load shows up on y in the same edge.
    onehot_enc #(
        .N          (N),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_enc (
        .sel (idx_next),
        .y   (y_enc)
    );

    always_comb begin
        idx_next  = idx;
        hold_next = hold_cnt;
        wrap_next = 1'b0;
        y_next    = Y_IDLE;
        if (en) begin
            y_next = y_enc;
            if (load) begin
                idx_next  = sel_in;
                hold_next = '0;
            end else if (mode_sel == MODE_SCAN) begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_next = '0;
                    idx_next  = idx + N'(1);
                    wrap_next = &idx;
                end else begin
                    hold_next = hold_cnt + HW'(1);
                end
            end else begin
                hold_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            hold_cnt <= '0;
            wrap     <= 1'b0;
            y        <= Y_IDLE;
        end else begin
            idx      <= idx_next;
            hold_cnt <= hold_next;
            wrap     <= wrap_next;
            y        <= y_next;
        end
    end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Bench for decoder_scan_nto2n: two configurations checked against an integer-level model every cycle.
module tb_decoder_scan_nto2n;

    typedef struct {
        int idx;
        int cnt;
        bit wrap;
        bit act;
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       en_a, mode_a, load_a;
    logic [1:0] sel_a, idx_a;
    logic [3:0] y_a;
    logic       wrap_a;

    logic       en_b, mode_b, load_b;
    logic [2:0] sel_b, idx_b;
    logic [7:0] y_b;
    logic       wrap_b;

    int vectors = 0;
    int miscompares = 0;

    mstate_t ma = '{default: 0};
    mstate_t mb = '{default: 0};

    always #5 clk = ~clk;

    decoder_scan_nto2n #(.N(2), .HOLD(20), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .load(load_a),
        .sel_in(sel_a), .y(y_a), .idx(idx_a), .wrap(wrap_a)
    );

    decoder_scan_nto2n #(.N(3), .HOLD(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .load(load_b),
        .sel_in(sel_b), .y(y_b), .idx(idx_b), .wrap(wrap_b)
    );

    // Scan position advances once per HOLD enabled scan cycles; loads restart the count.
    function automatic mstate_t mstep(input mstate_t s, input int n, input int hold,
                                      input bit en, input bit mode, input bit load, input int sel);
        mstate_t r;
        r = s;
        r.wrap = 1'b0;
        if (!en) begin
            r.act = 1'b0;
            return r;
        end
        r.act = 1'b1;
        if (load) begin
            r.idx = sel;
            r.cnt = 0;
        end else if (mode) begin
            r.cnt = s.cnt + 1;
            if (r.cnt == hold) begin
                r.cnt  = 0;
                r.wrap = (s.idx == (1 << n) - 1);
                r.idx  = (s.idx + 1) % (1 << n);
            end
        end else begin
            r.cnt = 0;
        end
        return r;
    endfunction

    function automatic logic [63:0] model_y(input mstate_t s, input int n, input bit al);
        logic [63:0] v;
        v = s.act ? (64'd1 << s.idx) : 64'd0;
        if (al) v = ~v & ((64'd1 << (1 << n)) - 64'd1);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = mstep(ma, 2, 20, en_a, mode_a, load_a, int'(sel_a));
            mb = mstep(mb, 3, 1, en_b, mode_b, load_b, int'(sel_b));
        end
    end

    always @(negedge clk) begin
        check("cyc_y_a",    64'(y_a),    model_y(ma, 2, 1'b0));
        check("cyc_idx_a",  64'(idx_a),  64'(ma.idx));
        check("cyc_wrap_a", 64'(wrap_a), 64'(ma.wrap));
        check("cyc_y_b",    64'(y_b),    model_y(mb, 3, 1'b1));
        check("cyc_idx_b",  64'(idx_b),  64'(mb.idx));
        check("cyc_wrap_b", 64'(wrap_b), 64'(mb.wrap));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        en_a = 1'b1; mode_a = 1'b0; load_a = 1'b0; sel_a = '0;
        en_b = 1'b0; mode_b = 1'b0; load_b = 1'b0; sel_b = '0;

        tick(2);
        check("rst_y_a", 64'(y_a), 64'h0);
        check("rst_y_b", 64'(y_b), 64'hFF);
        rst_n = 1'b1;
        tick(1);
        check("first_y_a", 64'(y_a), 64'b0001);

        load_a = 1'b1; sel_a = 2'd2;
        tick(1);
        load_a = 1'b0;
        check("load_y_a", 64'(y_a), 64'b0100);
        check("load_idx_a", 64'(idx_a), 64'd2);

        load_a = 1'b1; sel_a = 2'd0;
        tick(1);
        load_a = 1'b0; mode_a = 1'b1;
        tick(19); check("scan19_y", 64'(y_a), 64'b0001);
        tick(1);  check("scan20_y", 64'(y_a), 64'b0010);
        tick(20); check("scan40_y", 64'(y_a), 64'b0100);
        tick(20); check("scan60_y", 64'(y_a), 64'b1000);
        check("scan60_wrap", 64'(wrap_a), 64'd0);
        tick(20); check("scan80_y", 64'(y_a), 64'b0001);
        check("scan80_wrap", 64'(wrap_a), 64'd1);
        tick(1);  check("scan81_wrap", 64'(wrap_a), 64'd0);

        tick(19); check("pre_load_idx", 64'(idx_a), 64'd1);
        tick(10);
        load_a = 1'b1; sel_a = 2'd3;
        tick(1);
        load_a = 1'b0;
        check("midload_y", 64'(y_a), 64'b1000);
        tick(19); check("midload19_y", 64'(y_a), 64'b1000);
        tick(1);  check("midload20_y", 64'(y_a), 64'b0001);
        check("midload20_wrap", 64'(wrap_a), 64'd1);

        tick(60);
        tick(19);
        load_a = 1'b1; sel_a = 2'd2;
        tick(1);
        load_a = 1'b0;
        check("wrapload_wrap", 64'(wrap_a), 64'd0);
        check("wrapload_idx", 64'(idx_a), 64'd2);

        tick(5);
        en_a = 1'b0;
        tick(15);
        check("frz_y", 64'(y_a), 64'h0);
        check("frz_idx", 64'(idx_a), 64'd2);
        en_a = 1'b1;
        tick(14); check("unfrz14_y", 64'(y_a), 64'b0100);
        tick(1);  check("unfrz15_y", 64'(y_a), 64'b1000);

        load_a = 1'b1; sel_a = 2'd2;
        tick(1);
        load_a = 1'b0;
        tick(3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_y", 64'(y_a), 64'h0);
        check("arst_idx", 64'(idx_a), 64'd0);
        #2 rst_n = 1'b1;
        tick(1);  check("rstscan1_y", 64'(y_a), 64'b0001);
        tick(18); check("rstscan19_y", 64'(y_a), 64'b0001);
        tick(1);  check("rstscan20_y", 64'(y_a), 64'b0010);

        en_b = 1'b1; mode_b = 1'b1; load_b = 1'b1; sel_b = 3'd0;
        tick(1);
        load_b = 1'b0;
        check("b_load_y", 64'(y_b), 64'hFE);
        tick(1); check("b_step1_y", 64'(y_b), 64'hFD);
        tick(6); check("b_step7_y", 64'(y_b), 64'h7F);
        tick(1); check("b_wrap_y", 64'(y_b), 64'hFE);
        check("b_wrap", 64'(wrap_b), 64'd1);
        tick(1); check("b_after_wrap", 64'(wrap_b), 64'd0);
        en_b = 1'b0;
        tick(1); check("b_dis_y", 64'(y_b), 64'hFF);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
